// File: rtl/adc_serial_responder.sv
// Serial ADC stand-in: answers a cs_n/adclk master with a programmed sample, MSB first.
// The link pins are oversampled in the clk domain and every response is registered.
//
// state | meaning
// IDLE  | no frame; data line released
// SHIFT | frame active, sample bits still being delivered
// TAIL  | all DATA_W bits delivered; further adclk rises flag overrun
module adc_serial_responder #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              adclk,
    input  logic [DATA_W-1:0] sample_in,
    output logic              ad_out,
    output logic              ad_oe,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              overrun,
    output logic [15:0]       frame_cnt
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic                   cs_hist;
    logic                   clk_hist;
    logic [DATA_W-1:0]      shreg;
    logic [CNT_W-1:0]       rise_cnt;

    logic cs_fall;
    logic cs_rise;
    logic clk_rise;
    logic clk_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync  <= '1;
            clk_sync <= '0;
            cs_hist  <= 1'b1;
            clk_hist <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], adclk};
            cs_hist  <= cs_sync[SYNC_STAGES-1];
            clk_hist <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_fall  =  cs_hist  & ~cs_sync[SYNC_STAGES-1];
    assign cs_rise  = ~cs_hist  &  cs_sync[SYNC_STAGES-1];
    assign clk_rise = ~clk_hist &  clk_sync[SYNC_STAGES-1];
    assign clk_fall =  clk_hist & ~clk_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            rise_cnt    <= '0;
            ad_out      <= 1'b0;
            ad_oe       <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            overrun     <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= SHIFT;
                        shreg    <= sample_in;
                        ad_out   <= sample_in[DATA_W-1];
                        ad_oe    <= 1'b1;
                        busy     <= 1'b1;
                        rise_cnt <= '0;
                        overrun  <= 1'b0;
                    end
                end
                SHIFT, TAIL: begin
                    // cs_n rise has priority over any adclk edge in the same cycle
                    if (cs_rise) begin
                        state  <= IDLE;
                        ad_out <= 1'b0;
                        ad_oe  <= 1'b0;
                        busy   <= 1'b0;
                        if (rise_cnt == CNT_FULL) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end else begin
                            frame_abort <= 1'b1;
                        end
                    end else if (state == SHIFT) begin
                        if (clk_rise) begin
                            rise_cnt <= rise_cnt + 1'b1;
                            if (rise_cnt == CNT_LAST) begin
                                state  <= TAIL;
                                ad_out <= 1'b0;
                            end
                        end else if (clk_fall && rise_cnt != '0) begin
                            // a fall before the first rise keeps the MSB on the line
                            shreg  <= {shreg[DATA_W-2:0], 1'b0};
                            ad_out <= shreg[DATA_W-2];
                        end
                    end else begin
                        ad_out <= 1'b0;
                        if (clk_rise) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Bench for adc_serial_responder: a link master drives frames, expected bits are
// queued at frame start and popped at each adclk rise where the master samples ad_out.
module tb_adc_serial_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        adclk;
    logic [7:0]  sample_in;
    logic        ad_out;
    logic        ad_oe;
    logic        busy;
    logic        frame_done;
    logic        frame_abort;
    logic        overrun;
    logic [15:0] frame_cnt;

    adc_serial_responder #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cs_n        (cs_n),
        .adclk       (adclk),
        .sample_in   (sample_in),
        .ad_out      (ad_out),
        .ad_oe       (ad_oe),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .overrun     (overrun),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sample;
        int         n_rises;
        int         hi;
        int         lo;
        logic       exp_done;
        logic       exp_abort;
        logic       exp_ovr;
    } vec_t;

    vec_t        vecs[7];
    logic        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          done_seen = 0;
    int          abort_seen = 0;
    logic [15:0] exp_cnt = 16'd0;

    always @(negedge clk) begin
        if (frame_done)  done_seen  <= done_seen + 1;
        if (frame_abort) abort_seen <= abort_seen + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master samples ad_out just before driving each adclk rise
    task automatic rise_and_check(input int hi, input int lo);
        logic e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_underflow: got empty queue, expected a bit");
            e = 1'b0;
        end else begin
            e = exp_q.pop_front();
            check("ad_out_bit", 32'(ad_out), 32'(e));
        end
        adclk = 1'b1;
        wait_clks(hi);
        adclk = 1'b0;
        wait_clks(lo);
    endtask

    task automatic run_frame(input logic [7:0] s, input int n, input int hi, input int lo,
                             input logic e_done, input logic e_abort, input logic e_ovr);
        int d0;
        int a0;
        d0 = done_seen;
        a0 = abort_seen;
        sample_in = s;
        cs_n = 1'b0;
        wait_clks(6);
        check("busy_start", 32'(busy), 32'd1);
        check("oe_start", 32'(ad_oe), 32'd1);
        check("ovr_cleared", 32'(overrun), 32'd0);
        sample_in = ~s;
        for (int i = 0; i < n; i++) exp_q.push_back(i < 8 ? s[7-i] : 1'b0);
        for (int i = 0; i < n; i++) rise_and_check(hi, lo);
        cs_n = 1'b1;
        wait_clks(6);
        if (e_done) exp_cnt = exp_cnt + 16'd1;
        check("busy_end", 32'(busy), 32'd0);
        check("oe_end", 32'(ad_oe), 32'd0);
        check("ad_out_end", 32'(ad_out), 32'd0);
        check("done_pulses", 32'(done_seen - d0), 32'(e_done));
        check("abort_pulses", 32'(abort_seen - a0), 32'(e_abort));
        check("overrun", 32'(overrun), 32'(e_ovr));
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        int a0;
        vecs[0] = '{8'hA5, 8, 10, 10, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 5,  5,  5, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 10, 5,  5, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8,  5,  5, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h5A, 0,  5,  5, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h96, 7,  4,  4, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'hC3, 8,  4,  4, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        cs_n = 1'b1;
        adclk = 1'b0;
        sample_in = 8'h00;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(1);
        check("rst_ad_out", 32'(ad_out), 32'd0);
        check("rst_ad_oe", 32'(ad_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_abort", 32'(frame_abort), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

        d0 = done_seen;
        a0 = abort_seen;
        for (int i = 0; i < 10; i++) begin
            adclk = ~adclk;
            wait_clks(5);
            check("idle_oe", 32'(ad_oe), 32'd0);
        end
        check("idle_no_pulse", 32'((done_seen - d0) + (abort_seen - a0)), 32'd0);
        adclk = 1'b0;
        wait_clks(5);

        for (int v = 0; v < 7; v++)
            run_frame(vecs[v].sample, vecs[v].n_rises, vecs[v].hi, vecs[v].lo,
                      vecs[v].exp_done, vecs[v].exp_abort, vecs[v].exp_ovr);

        // Reset in the middle of a frame
        d0 = done_seen;
        a0 = abort_seen;
        sample_in = 8'h81;
        cs_n = 1'b0;
        wait_clks(6);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) rise_and_check(5, 5);
        rst = 1'b1;
        wait_clks(1);
        exp_cnt = 16'd0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_oe", 32'(ad_oe), 32'd0);
        check("midrst_cnt", 32'(frame_cnt), 32'd0);
        cs_n = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(6);
        check("midrst_no_pulse", 32'((done_seen - d0) + (abort_seen - a0)), 32'd0);
        run_frame(8'h81, 8, 5, 5, 1'b1, 1'b0, 1'b0);

        // frame_cnt wrap from 0xFFFF
        force dut.frame_cnt = 16'hFFFF;
        wait_clks(1);
        release dut.frame_cnt;
        wait_clks(1);
        exp_cnt = 16'hFFFF;
        check("preload_cnt", 32'(frame_cnt), 32'hFFFF);
        run_frame(8'h69, 8, 5, 5, 1'b1, 1'b0, 1'b0);
        check("wrap_cnt", 32'(frame_cnt), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_serial_responder.md
Name: adc_serial_responder

Overview:
- Synthesizable responder for the 3-wire serial ADC link (cs_n, adclk, ad_in): the link master drives cs_n and adclk; this block drives the data line back.
- Used in hardware-in-the-loop and self-test builds in place of the physical ADC, so the protection/control unit can be exercised with programmed sample values.
- Oversamples cs_n and adclk in the system clock domain, shifts out one DATA_W-bit sample per frame MSB first, and reports frame completion or abort.

Parameters:
- DATA_W, 8, sample width in bits.
- SYNC_STAGES, 2, synchronizer flops on cs_n and adclk; legal values are 2 or 3.

Ports:
- clk  input  1  system clock; all logic runs on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cs_n  input  1  chip select from the link master, active low, asynchronous to clk.
- adclk  input  1  serial clock from the link master, asynchronous to clk; the master samples data on the adclk rising edge.
- sample_in  input  DATA_W  value to return in the next frame; captured at the cs_n falling edge.
- ad_out  output  1  serial data to the master (feeds ad_in).
- ad_oe  output  1  data-line drive enable; 1 only while a frame is active.
- busy  output  1  high while a frame is active.
- frame_done  output  1  one-cycle pulse: frame ended with at least DATA_W adclk rising edges.
- frame_abort  output  1  one-cycle pulse: frame ended with fewer than DATA_W adclk rising edges.
- overrun  output  1  sticky flag: an adclk rising edge arrived after all DATA_W bits were delivered; cleared at the next frame start.
- frame_cnt  output  16  count of completed frames; wraps from 0xFFFF to 0x0000.

Behaviour:
- Reset values: ad_out=0, ad_oe=0, busy=0, frame_done=0, frame_abort=0, overrun=0, frame_cnt=0. The shift register, bit counter and edge-detect history are cleared. The synchronizers are loaded with cs_n=1 and adclk=0.
- Synchronizer and edge detection:
  - cs_n and adclk each pass through SYNC_STAGES flops, then one history flop.
  - An edge is declared when the last synchronizer stage differs from the history flop.
  - Any output response is registered, so it appears SYNC_STAGES+1 clk cycles after the pin edge is first sampled.
- State machine with states IDLE, SHIFT, TAIL:
  - IDLE → SHIFT on cs_n fall:
    - shreg := sample_in; ad_out := sample_in[DATA_W-1]; ad_oe := 1; busy := 1.
    - rise_cnt := 0; overrun := 0.
  - SHIFT, on adclk rise: rise_cnt := rise_cnt+1. When it reaches DATA_W, go to TAIL.
  - SHIFT, on adclk fall with rise_cnt ≥ 1: shift shreg left by one, fill with 0, and set ad_out := new MSB. A falling edge before the first rising edge is ignored, so the MSB stays valid for the first rise.
  - TAIL: ad_out := 0. Any adclk rise sets overrun := 1. rise_cnt saturates at DATA_W.
  - SHIFT or TAIL → IDLE on cs_n rise:
    - ad_oe := 0; ad_out := 0; busy := 0.
    - If rise_cnt = DATA_W: frame_done pulses for 1 cycle and frame_cnt increments.
    - Otherwise: frame_abort pulses for 1 cycle and frame_cnt is unchanged.
- Simultaneous events in one cycle:
  - cs_n rise and adclk edge together: the cs_n rise wins and the adclk edge is discarded.
  - cs_n fall together with an adclk edge: the adclk edge is discarded.
  - adclk rise and fall detected together cannot occur, because there is one sync chain per signal.
- cs_n fall while not in IDLE cannot occur without an intervening rise. An edge on adclk while IDLE is ignored.
- rst asserted mid-frame: immediate return to IDLE with all reset values. No frame_done or frame_abort is emitted. frame_cnt returns to 0.
- sample_in is sampled only at the frame-start cycle; changes during a frame do not affect the frame.
- The design assumes adclk high and low phases each last at least SYNC_STAGES+2 clk cycles. Faster adclk is out of spec and its behaviour is undefined.

Test Plan:
- rst=1 for 3 cycles with cs_n=1 → all outputs 0 and frame_cnt=0; ad_oe stays 0 across 10 adclk toggles while cs_n=1.
- sample_in=0xA5; cs_n low; 8 adclk periods of 10 clk high / 10 clk low; cs_n high → the bits sampled at adclk rises are 1,0,1,0,0,1,0,1; frame_done pulses once; frame_cnt=1; overrun=0.
- sample_in=0x3C; cs_n low; only 5 adclk rises, then cs_n high → bits 0,0,1,1,1 observed; frame_abort pulses once; frame_done=0; frame_cnt unchanged.
- sample_in=0xFF; 10 adclk rises in one frame → rises 9 and 10 see ad_out=0; overrun=1 until the next cs_n fall; frame_done pulses.
- sample_in=0x81; assert rst after 3 rises → busy=0 and ad_oe=0 on the next cycle, with no done or abort pulse; a following full frame returns 0x81 correctly.
- Preload frame_cnt to 0xFFFF by running 65535 frames, or by a forced preload in the bench; one more full frame → frame_cnt=0x0000.
